dma_m2m_copy_engine: RTL
========================

Name: dma_m2m_copy_engine

Overview:
- Memory-to-memory copy engine; the Avalon-MM master stage directly upstream of the on-chip memories in the DMA subsystem.
- Nios II programs source, destination and length through a CSR slave.
- The engine streams 32-bit words from the source memory through an internal FIFO into the destination memory, then raises done and irq.
- Addresses are word addresses matching the 17-bit on-chip memory address bus.

Parameters:
ADDR_W, 17, word-address width of rd_address/wr_address and SRC/DST registers
LEN_W, 17, width of the word-count register
FIFO_DEPTH, 8, buffer entries (power of 2, ≥2); also bounds reads outstanding plus buffered

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
csr_address  in  3  CSR word offset
csr_chipselect  in  1  CSR select
csr_read  in  1  CSR read strobe
csr_write  in  1  CSR write strobe
csr_writedata  in  32  CSR write data
csr_readdata  out  32  CSR read data, 1-cycle latency
irq  out  1  done & IRQ_EN
rd_address  out  ADDR_W  source word address
rd_read  out  1  read request
rd_waitrequest  in  1  read stall
rd_readdata  in  32  returned data
rd_readdatavalid  in  1  returned-data strobe
wr_address  out  ADDR_W  destination word address
wr_write  out  1  write request
wr_writedata  out  32  write data
wr_byteenable  out  4  constant 4'hF
wr_waitrequest  in  1  write stall

Behaviour:
- Reset is evaluated only on a clk edge with reset_n=0. Reset values: every register 0; rd_read=0; wr_write=0; irq=0; csr_readdata=0; FIFO empty; outstanding=0; state IDLE.
- CSR map:
  - 0 STATUS: b0 busy (RO), b1 done (write 1 to clear), b2 aborted (write 1 to clear).
  - 1 SRC, 2 DST, 3 LEN: RW.
  - 4 CTRL: b0 GO (self-clearing, reads 0), b1 ABORT (self-clearing), b2 IRQ_EN.
  - 5 REMAIN: words not yet written (RO).
  - Offsets 6-7 read 0.
- csr_readdata registers one cycle after csr_chipselect&csr_read. Writes to SRC/DST/LEN while busy are ignored.
- States:
  - IDLE→BUSY on GO with LEN≠0. Working counters load SRC/DST/LEN; done and aborted clear.
  - GO with LEN=0 sets done in the next cycle and stays IDLE.
  - GO while busy is ignored.
  - BUSY→IDLE when the write counter reaches 0 after the last accepted write. done=1 in the same transition.
  - BUSY→ABORT on ABORT.
  - ABORT: no new reads or writes issue, and wr_write/rd_read drop in the next cycle. Returning rd_readdatavalid data is discarded.
  - ABORT→IDLE when outstanding=0. The FIFO flushes and aborted=1; done stays 0.
  - ABORT in IDLE has no effect.
- Read issue:
  - rd_read is asserted while BUSY, reads remain, and outstanding+fifo_count < FIFO_DEPTH.
  - A read is accepted when rd_read & ~rd_waitrequest. On acceptance, rd_address increments, the read counter decrements and outstanding increments.
  - rd_address/rd_read stay stable while rd_waitrequest=1.
- rd_readdatavalid pushes rd_readdata into the FIFO and decrements outstanding. A same-cycle accept and return leaves outstanding unchanged. The credit rule guarantees no FIFO overflow. Data is assumed in order.
- Write issue:
  - wr_write is asserted while BUSY and the FIFO is not empty. wr_writedata is the FIFO head.
  - A write is accepted when wr_write & ~wr_waitrequest. On acceptance the FIFO pops, wr_address increments and REMAIN decrements.
  - Outputs hold while stalled. A same-cycle FIFO push and pop keeps the count unchanged.
- Throughput is 1 word/clk with zero waitrequest and 1-cycle read latency. The first write occurs 2 cycles after the first read accept (1 cycle memory + 1 cycle FIFO registration).
- Addresses wrap modulo 2^ADDR_W with no error.
- irq = done & IRQ_EN, registered. It clears when done is cleared by W1C or a new GO.
- reset_n low mid-transfer: immediate return to the reset state on that edge. In-flight reads are abandoned.

Test Plan:
- SRC=0x100, DST=0x800, LEN=16, GO, slave with 1-cycle latency and no stalls -> 16 writes to 0x800..0x80F with source data; busy for 16+3 cycles ±1; done=1; REMAIN=0.
- Same copy with random rd_waitrequest/wr_waitrequest (30%) and readdatavalid latency 1-4 -> identical data order; outstanding+FIFO never exceeds 8.
- LEN=0 with GO -> no rd_read/wr_write; done=1 one cycle later; irq=1 when IRQ_EN=1; writing STATUS=0x2 clears irq.
- LEN=100, ABORT after 20 writes with 3 reads outstanding -> no further wr_write; the 3 returns are discarded; aborted=1, done=0, REMAIN=80.
- SRC=0x1FFFE, LEN=4 -> rd_address sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- reset_n=0 for 1 cycle mid-copy -> next cycle all outputs 0, STATUS=0, state IDLE; a following GO copies correctly.

Source files
------------

// File: rtl/dma_m2m_copy_engine.sv
`timescale 1ns/1ps
// Memory-to-memory copy engine: CSR-programmed word copy from an Avalon-MM read master into an Avalon-MM write master.
// Internal FIFO with credit-bounded reads; both masters hold outputs under waitrequest, steady state 1 word/clk.
module dma_m2m_copy_engine #(
  parameter int ADDR_W     = 17,
  parameter int LEN_W      = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_read,
  input  logic              rd_waitrequest,
  input  logic [31:0]       rd_readdata,
  input  logic              rd_readdatavalid,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_write,
  output logic [31:0]       wr_writedata,
  output logic [3:0]        wr_byteenable,
  input  logic              wr_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  len_q, len_d, rd_cnt_q, rd_cnt_d, remain_q, remain_d;
  logic              irq_en_q, irq_en_d, done_q, done_d, aborted_q, aborted_d, irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  out_q, out_d, fcnt_q, fcnt_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];

  logic csr_wr, csr_rd, go, abort, busy, credit_ok;
  logic rd_fire, wr_fire, push, pop, ret;
  logic unused_wdata;

  assign csr_wr = csr_chipselect & csr_write;
  assign csr_rd = csr_chipselect & csr_read;
  assign go     = csr_wr && (csr_address == 3'd4) && csr_writedata[0];
  assign abort  = csr_wr && (csr_address == 3'd4) && csr_writedata[1];
  assign busy   = (state_q != S_IDLE);
  assign unused_wdata = ^csr_writedata;

  // Reads in flight plus buffered words never exceed the FIFO, so a return always has room.
  assign credit_ok = ({1'b0, out_q} + {1'b0, fcnt_q}) < SUM_W'(FIFO_DEPTH);
  assign rd_read   = (state_q == S_BUSY) && (rd_cnt_q != '0) && credit_ok;
  assign wr_write  = (state_q == S_BUSY) && (fcnt_q != '0);
  assign rd_fire   = rd_read & ~rd_waitrequest;
  assign wr_fire   = wr_write & ~wr_waitrequest;
  assign push      = rd_readdatavalid && (state_q == S_BUSY);
  assign pop       = wr_fire;
  // Stray returns after a reset find outstanding at zero and are dropped.
  assign ret       = rd_readdatavalid && (out_q != '0);

  assign rd_address    = rd_addr_q;
  assign wr_address    = wr_addr_q;
  assign wr_writedata  = mem_q[rptr_q];
  assign wr_byteenable = 4'hF;
  assign irq           = irq_q;
  assign csr_readdata  = rdata_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_cnt_d  = rd_cnt_q;
    remain_d  = remain_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    rdata_d   = rdata_q;
    out_d     = out_q;
    fcnt_d    = fcnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;

    if (csr_wr) begin
      case (csr_address)
        3'd0: begin
          if (csr_writedata[1]) done_d = 1'b0;
          if (csr_writedata[2]) aborted_d = 1'b0;
        end
        3'd1: if (!busy) src_d = ADDR_W'(csr_writedata);
        3'd2: if (!busy) dst_d = ADDR_W'(csr_writedata);
        3'd3: if (!busy) len_d = LEN_W'(csr_writedata);
        3'd4: irq_en_d = csr_writedata[2];
        default: ;
      endcase
    end

    if (csr_rd) begin
      case (csr_address)
        3'd0:    rdata_d = {29'd0, aborted_q, done_q, busy};
        3'd1:    rdata_d = 32'(src_q);
        3'd2:    rdata_d = 32'(dst_q);
        3'd3:    rdata_d = 32'(len_q);
        3'd4:    rdata_d = {29'd0, irq_en_q, 2'b00};
        3'd5:    rdata_d = 32'(remain_q);
        default: rdata_d = 32'd0;
      endcase
    end

    if (rd_fire) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      rd_cnt_d  = rd_cnt_q - LEN_W'(1);
    end
    case ({rd_fire, ret})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: ;
    endcase

    if (push) begin
      mem_d[wptr_q] = rd_readdata;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: ;
    endcase

    if (wr_fire) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      remain_d  = remain_q - LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          aborted_d = 1'b0;
          if (len_q != '0) begin
            state_d   = S_BUSY;
            done_d    = 1'b0;
            rd_addr_d = src_q;
            wr_addr_d = dst_q;
            rd_cnt_d  = len_q;
            remain_d  = len_q;
          end else begin
            done_d   = 1'b1;
            remain_d = '0;
          end
        end
      end
      S_BUSY: begin
        // A final write landing with an ABORT still counts as a completed copy.
        if (wr_fire && (remain_q == LEN_W'(1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (out_q == '0) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
          wptr_d    = '0;
          rptr_d    = '0;
          fcnt_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_cnt_q  <= '0;
      remain_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      fcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      remain_q  <= remain_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      fcnt_q    <= fcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule
